// File: rtl/ex_mem_stage_buf.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_buf
//
// EX/MEM pipeline register built as a 2-entry skid buffer with a
// valid/ready handshake on both sides and a synchronous flush for branch
// mispredicts. Every output comes straight from a flop, so there is no
// combinational path from any input to any output. In particular, in_ready
// is registered, so MEM backpressure never reaches EX combinationally.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   flush             drop buffered entries and any input offered this cycle
//   in_valid/in_ready EX-side handshake (in_ready is registered)
//   in_*              entry payload: ctrl, result, store data, branch target,
//                     zero flag, destination register
//   out_valid/out_ready MEM-side handshake
//   out_*             head entry payload
//   occupancy         number of entries held (0..2)
//
// Optional feature: define EX_MEM_STATS_EN to add the saturating counters
//   stall_cnt (cycles with out_valid & !out_ready) and
//   flush_cnt (cycles with flush asserted).
// ---------------------------------------------------------------------------
module ex_mem_stage_buf #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [DATA_W-1:0] in_branch_tgt,
    input  logic              in_zero,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [DATA_W-1:0] out_branch_tgt,
    output logic              out_zero,
    output logic [REG_W-1:0]  out_rd,
    output logic [1:0]        occupancy
`ifdef EX_MEM_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // State encoding equals the entry count, so occupancy is the state flop.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    localparam int PAY_W = CTRL_W + 3 * DATA_W + 1 + REG_W;

    logic [1:0]       state_q, state_d;
    logic [PAY_W-1:0] head_q, head_d;
    logic [PAY_W-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [PAY_W-1:0] in_pay;
    logic             accept;
    logic             emit;

    assign in_pay = {in_ctrl, in_result, in_store_data, in_branch_tgt, in_zero, in_rd};
    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // An emit this cycle has already completed from MEM's side; the
            // offered input is simply not taken.
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_pay;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({accept, emit})
                        2'b11: head_d = in_pay;
                        2'b10: begin
                            skid_d  = in_pay;
                            state_d = TWO;
                        end
                        2'b01: state_d = EMPTY;
                        default: ;
                    endcase
                end
                TWO: begin
                    // in_ready is low here, so only the emit matters.
                    if (emit) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Ready is a function of the next state, so it is valid from the
        // cycle the state is entered without any input-to-output path.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign {out_ctrl, out_result, out_store_data, out_branch_tgt, out_zero, out_rd} = head_q;

`ifdef EX_MEM_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage_buf
//
// Directed scenarios followed by random traffic. The reference model is a
// plain queue of entries: reset and flush empty it, an emit pops the front,
// an accept pushes the back, and ready means fewer than two entries remain.
// Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage_buf;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [63:0] result;
        logic [63:0] store;
        logic [63:0] tgt;
        logic        zero;
        logic [4:0]  rd;
    } pay_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [63:0] in_result, in_store_data, in_branch_tgt;
    logic [63:0] out_result, out_store_data, out_branch_tgt;
    logic        in_zero, out_zero;
    logic [4:0]  in_rd, out_rd;
    logic [1:0]  occupancy;
`ifdef EX_MEM_STATS_EN
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    ex_mem_stage_buf #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_result(in_result), .in_store_data(in_store_data),
        .in_branch_tgt(in_branch_tgt), .in_zero(in_zero), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_result(out_result), .out_store_data(out_store_data),
        .out_branch_tgt(out_branch_tgt), .out_zero(out_zero), .out_rd(out_rd),
        .occupancy(occupancy)
`ifdef EX_MEM_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    pay_t q[$];
    bit   m_ready    = 1'b0;
    bit   zero_known = 1'b0;   // head known to be cleared (after reset/flush)
    int   m_stall    = 0;
    int   m_flush    = 0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic pay_t rand_pay();
        pay_t p;
        p.ctrl   = 8'($urandom);
        p.result = {$urandom, $urandom};
        p.store  = {$urandom, $urandom};
        p.tgt    = {$urandom, $urandom};
        p.zero   = 1'($urandom);
        p.rd     = 5'($urandom);
        return p;
    endfunction

    // One clock cycle: drive, clock, update model, compare.
    task automatic step(input bit rst_n, input bit fl, input bit iv, input bit ordy, input pay_t p);
        bit   pre_valid;
        bit   acc;
        pay_t e;
        reset = rst_n; flush = fl; in_valid = iv; out_ready = ordy;
        in_ctrl = p.ctrl; in_result = p.result; in_store_data = p.store;
        in_branch_tgt = p.tgt; in_zero = p.zero; in_rd = p.rd;
        @(posedge clk);
        pre_valid = (q.size() > 0);
        if (!rst_n) begin
            q.delete();
            m_ready = 1'b0; zero_known = 1'b1; m_stall = 0; m_flush = 0;
        end else begin
            if (pre_valid && !ordy && m_stall < CNT_MAX) m_stall++;
            if (fl && m_flush < CNT_MAX) m_flush++;
            if (fl) begin
                q.delete();
                zero_known = 1'b1;
            end else begin
                acc = iv && m_ready;
                if (pre_valid && ordy) begin
                    e = q.pop_front();
                    $display("emit  rd=%0d result=%h", e.rd, e.result);
                end
                if (acc) begin
                    q.push_back(p);
                    zero_known = 1'b0;
                end
            end
            m_ready = (q.size() < 2);
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("in_ready",  64'(in_ready),  64'(m_ready));
        if (q.size() > 0) begin
            check("out_ctrl",   64'(out_ctrl),   64'(q[0].ctrl));
            check("out_result", out_result,      q[0].result);
            check("out_store",  out_store_data,  q[0].store);
            check("out_tgt",    out_branch_tgt,  q[0].tgt);
            check("out_zero",   64'(out_zero),   64'(q[0].zero));
            check("out_rd",     64'(out_rd),     64'(q[0].rd));
        end else if (zero_known) begin
            check("out_cleared", 64'({out_ctrl, out_zero, out_rd}) | out_result
                                 | out_store_data | out_branch_tgt, 64'd0);
        end
`ifdef EX_MEM_STATS_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    initial begin
        pay_t p;
        pay_t z;
        z = '0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_result = '0; in_store_data = '0; in_branch_tgt = '0;
        in_zero = 1'b0; in_rd = '0;

        // Reset held 3 cycles while EX offers data
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, rand_pay());
        check("rst_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, z);
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Streaming with MEM always ready
        for (int i = 1; i <= 3; i++) begin
            p = rand_pay(); p.result = 64'(i * 16);
            step(1'b1, 1'b0, 1'b1, 1'b1, p);
            check("stream_res", out_result, 64'(i * 16));
            check("stream_occ", 64'(occupancy), 64'd1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, z);

        // Backpressure: fill both entries, then drain
        p = rand_pay(); p.rd = 5'd3; step(1'b1, 1'b0, 1'b1, 1'b0, p);
        p = rand_pay(); p.rd = 5'd7; step(1'b1, 1'b0, 1'b1, 1'b0, p);
        check("bp_occ", 64'(occupancy), 64'd2);
        check("bp_rd_held", 64'(out_rd), 64'd3);
        step(1'b1, 1'b0, 1'b1, 1'b0, rand_pay());   // ignored: in_ready=0
        check("bp_hold_rd", 64'(out_rd), 64'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1, z);
        check("bp_next_rd", 64'(out_rd), 64'd7);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, z);

        // Flush in TWO with a simultaneous offer
        step(1'b1, 1'b0, 1'b1, 1'b0, rand_pay());
        step(1'b1, 1'b0, 1'b1, 1'b0, rand_pay());
        p = rand_pay(); p.result = 64'hAA;
        step(1'b1, 1'b1, 1'b1, 1'b0, p);
        check("flush_occ", 64'(occupancy), 64'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1, z);

        // Reset while stalled with two entries
        step(1'b1, 1'b0, 1'b1, 1'b0, rand_pay());
        step(1'b1, 1'b0, 1'b1, 1'b0, rand_pay());
        step(1'b0, 1'b0, 1'b0, 1'b0, z);
        step(1'b1, 1'b0, 1'b0, 1'b1, z);
        p = rand_pay(); p.result = 64'h55;
        step(1'b1, 1'b0, 1'b1, 1'b1, p);
        check("rst_push55", out_result, 64'h55);
        step(1'b1, 1'b0, 1'b0, 1'b1, z);
        check("rst_alone", 64'(out_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) != 0), ($urandom_range(15) == 0),
                 ($urandom_range(9) < 7), ($urandom_range(9) < 6), rand_pay());
        end

`ifdef EX_MEM_STATS_EN
        // Saturating stall counter and flush counter from a clean reset
        step(1'b0, 1'b0, 1'b0, 1'b0, z);
        step(1'b1, 1'b0, 1'b0, 1'b0, z);
        step(1'b1, 1'b0, 1'b1, 1'b0, rand_pay());
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, z);
        check("stall_sat", 64'(stall_cnt), 64'd15);
        step(1'b1, 1'b1, 1'b0, 1'b1, z);
        step(1'b1, 1'b0, 1'b0, 1'b1, z);
        step(1'b1, 1'b1, 1'b0, 1'b1, z);
        check("flush_two", 64'(flush_cnt), 64'd2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage_buf.md
Name: ex_mem_stage_buf

Overview:
- Parametrised successor to the fixed EX/MEM pipeline register, sitting between the execute and memory stages of the 64-bit pipeline.
- Adds a valid/ready handshake so the memory stage can stall without combinational ready paths back into EX.
- Built as a 2-entry skid buffer, so EX keeps full throughput while MEM stalls.
- Adds a synchronous flush for branch mispredicts.

Parameters:
- DATA_W, 64, width of ALU result, store data and branch target
- REG_W, 5, destination register index width
- CTRL_W, 8, packed control word: Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp[1:0], LSB first
- CNT_W, 16, width of statistics counters (optional feature only)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  discard all buffered entries and any input offered this cycle
- in_valid  in  1  EX presents a valid entry
- in_ready  out  1  buffer can accept; registered output
- in_ctrl  in  CTRL_W  control word
- in_result  in  DATA_W  ALU result
- in_store_data  in  DATA_W  register read data 2
- in_branch_tgt  in  DATA_W  branch adder output
- in_zero  in  1  ALU zero flag
- in_rd  in  REG_W  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM consumes head
- out_ctrl / out_result / out_store_data / out_branch_tgt / out_zero / out_rd  out  as inputs  head entry fields
- occupancy  out  2  entries held, 0..2

Behaviour:
- Interface: one clock, clk; synchronous active-low reset on port reset. No other clock or reset exists.
- Reset: all out_* fields 0, out_valid=0, occupancy=0, state EMPTY, in_ready=0 while reset is low.
  - in_ready is 1 on the first cycle after release.
  - Reset is sampled only at the clk edge; asserting it mid-transfer discards everything.
- Storage:
  - Head register drives the out_* ports directly.
  - Skid register holds the second entry.
  - No combinational path from any input to any output.
- Accept: in_valid & in_ready at edge. Emit: out_valid & out_ready at edge.
- States, with occupancy equal to the state count:
  - EMPTY: accept -> ONE; data loads into head.
  - ONE:
    - accept & emit -> ONE; head reloads from input.
    - accept only -> TWO; input goes to skid.
    - emit only -> EMPTY.
    - neither -> ONE.
  - TWO:
    - emit -> ONE; skid moves to head.
    - no emit -> TWO.
    - in_ready=0, so no accept occurs in TWO.
- in_ready = next_state != TWO, registered.
  - One idle cycle of in_ready=0 after filling is acceptable.
  - The bench must not infer a combinational ready.
- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. one cycle, when the buffer was EMPTY or emitting.
- Ordering: strict FIFO; no entry is duplicated or dropped except by flush.
- Flush (sync, active-high):
  - Next state EMPTY; out_valid=0; head and skid payloads cleared to 0.
  - An input offered in the same cycle is dropped, even if in_ready=1.
  - An emit in the same cycle still completes from MEM's view, because out_ready was sampled against the old head.
- Priority: reset > flush > accept/emit.
- Field widths pass through unchanged; no arithmetic on payload.
- out_* hold stable while out_valid=1 & out_ready=0.

Optional Feature:
- Macro: EX_MEM_STATS_EN.
- Defined:
  - Adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W], both reset to 0.
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - flush_cnt increments each cycle flush=1.
  - Both counters saturate at all-ones; no wrap.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, occupancy=0, in_ready=0; after release in_ready=1 and out_* all 0.
- Streaming: out_ready=1, push results 0x10,0x20,0x30 on consecutive cycles -> each appears one cycle later in order; occupancy stays 1; no bubbles.
- Backpressure: out_ready=0, push rd=3 then rd=7 -> occupancy=2, in_ready=0, out_rd=3 held. Then out_ready=1 -> rd=3 emitted, next cycle out_rd=7, in_ready returns to 1.
- Flush in TWO: with occupancy=2, assert flush with in_valid=1 and in_result=0xAA -> next cycle occupancy=0, out_valid=0, 0xAA never emitted.
- Reset mid-stall: occupancy=2, pull reset low for one edge -> all cleared; subsequent push of 0x55 emerges alone.
- Stats (EX_MEM_STATS_EN, CNT_W=4): hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); 2 flush pulses -> flush_cnt=2.
